// File: rtl/commit_controller_pkg.sv
// Shared CPU definitions for the commit stage: ROB tag width default,
// head entry type encodings (also used by the ROB and decoder) and the
// commit controller state encoding.
package commit_controller_pkg;

    localparam int ROB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        HEAD_REG    = 2'd0,
        HEAD_BRANCH = 2'd1,
        HEAD_STORE  = 2'd2,
        HEAD_OTHER  = 2'd3
    } head_type_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_STORE = 2'd1,
        ST_FLUSH      = 2'd2
    } commit_state_e;

    // Entry types whose result goes back to the register file.
    function automatic logic writes_rd(input logic [1:0] head_type);
        return (head_type == HEAD_REG) || (head_type == HEAD_BRANCH);
    endfunction

endpackage

// File: rtl/commit_controller_if.sv
// Commit-stage bus: ROB head view, register-file write port, store commit
// handshake and flush/redirect outputs. The master side is the controller.
interface commit_controller_if
    import commit_controller_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) ();

    // ROB head
    logic                 headValid;
    logic                 headReady;
    logic [ROB_WIDTH-1:0] headId;
    logic [1:0]           headType;
    logic [4:0]           headRd;
    logic [31:0]          headValue;
    logic                 headMispredict;
    logic [31:0]          headTarget;
    logic                 headPop;

    // Register-file write
    logic                 writeFlag;
    logic [ROB_WIDTH-1:0] robId;
    logic [4:0]           writeAddr;
    logic [31:0]          writeValue;

    // Store commit
    logic                 storeCommit;
    logic [ROB_WIDTH-1:0] storeRobId;
    logic                 storeDone;

    // Flush / redirect
    logic                 clearOut;
    logic                 redirectValid;
    logic [31:0]          redirectPc;

    logic [31:0]          commitCount;

    modport master (
        input  headValid, headReady, headId, headType, headRd, headValue,
               headMispredict, headTarget, storeDone,
        output headPop, writeFlag, robId, writeAddr, writeValue,
               storeCommit, storeRobId, clearOut, redirectValid, redirectPc,
               commitCount
    );

    modport slave (
        output headValid, headReady, headId, headType, headRd, headValue,
               headMispredict, headTarget, storeDone,
        input  headPop, writeFlag, robId, writeAddr, writeValue,
               storeCommit, storeRobId, clearOut, redirectValid, redirectPc,
               commitCount
    );

endinterface

// File: rtl/commit_controller.sv
// In-order commit controller. Retires the ROB head one entry per cycle,
// writes results to the register file one cycle later, holds stores until
// the memory side acknowledges, and flushes/redirects on a mispredict.
module commit_controller
    import commit_controller_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    commit_controller_if.master  bus
);

    commit_state_e        state;
    commit_state_e        state_next;

    logic                 head_pop;
    logic                 fire;
    logic                 rd_write;
    logic                 store_fire;
    logic                 store_release;
    logic                 mispredict;

    logic                 write_flag;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [4:0]           write_addr;
    logic [31:0]          write_value;
    logic                 store_commit;
    logic [ROB_WIDTH-1:0] store_rob_id;
    logic                 clear_out;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [31:0]          commit_count;

    // State register; readyIn low freezes the FSM, reset wins over everything.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state <= ST_RUN;
        end else if (readyIn) begin
            state <= state_next;
        end
    end

    // Next state and per-cycle commit decisions (pop, write, store, flush).
    always_comb begin
        state_next    = state;
        head_pop      = 1'b0;
        fire          = 1'b0;
        rd_write      = 1'b0;
        store_fire    = 1'b0;
        store_release = 1'b0;
        mispredict    = 1'b0;

        unique case (state)
            ST_RUN: begin
                fire = readyIn && bus.headValid && bus.headReady;
                if (fire) begin
                    if (bus.headType == HEAD_STORE) begin
                        // Store stays at the head until memory acknowledges it.
                        store_fire = 1'b1;
                        state_next = ST_WAIT_STORE;
                    end else begin
                        head_pop = 1'b1;
                        rd_write = writes_rd(bus.headType) && (bus.headRd != 5'd0);
                        if ((bus.headType == HEAD_BRANCH) && bus.headMispredict) begin
                            mispredict = 1'b1;
                            state_next = ST_FLUSH;
                        end
                    end
                end
            end
            ST_WAIT_STORE: begin
                if (readyIn && bus.storeDone) begin
                    head_pop      = 1'b1;
                    store_release = 1'b1;
                    state_next    = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // One dead cycle while the flush propagates to the queues.
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (resetIn) begin
            head_pop = 1'b0;
        end
    end

    // Registered outputs: pulses re-evaluated each enabled cycle, data latched
    // only when its strobe fires so stale values remain visible otherwise.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            write_flag     <= 1'b0;
            rob_id         <= '0;
            write_addr     <= 5'd0;
            write_value    <= 32'd0;
            store_commit   <= 1'b0;
            store_rob_id   <= '0;
            clear_out      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            commit_count   <= 32'd0;
        end else if (readyIn) begin
            write_flag <= rd_write;
            if (rd_write) begin
                rob_id      <= bus.headId;
                write_addr  <= bus.headRd;
                write_value <= bus.headValue;
            end

            clear_out      <= mispredict;
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= bus.headTarget;
            end

            if (store_fire) begin
                store_commit <= 1'b1;
                store_rob_id <= bus.headId;
            end else if (store_release) begin
                store_commit <= 1'b0;
            end

            if (head_pop) begin
                commit_count <= commit_count + 32'd1;
            end
        end
    end

    assign bus.headPop       = head_pop;
    assign bus.writeFlag     = write_flag;
    assign bus.robId         = rob_id;
    assign bus.writeAddr     = write_addr;
    assign bus.writeValue    = write_value;
    assign bus.storeCommit   = store_commit;
    assign bus.storeRobId    = store_rob_id;
    assign bus.clearOut      = clear_out;
    assign bus.redirectValid = redirect_valid;
    assign bus.redirectPc    = redirect_pc;
    assign bus.commitCount   = commit_count;

endmodule

// File: tb/tb_commit_controller.sv
// Testbench for commit_controller: directed vector table, hand-written
// store/mispredict/reset sequences, and randomized traffic, all checked
// against a behavioural model of the retirement rules.
module tb_commit_controller;

    localparam int RW = 4;

    logic clk;
    logic rst;
    logic rdy;

    commit_controller_if #(.ROB_WIDTH(RW)) bus ();

    commit_controller #(.ROB_WIDTH(RW)) dut (
        .clockIn (clk),
        .resetIn (rst),
        .readyIn (rdy),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          hv;
        bit          hr;
        logic [1:0]  typ;
        logic [RW-1:0] id;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
        bit          sd;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          e_pop;
        bit          e_wf;
        logic [RW-1:0] e_rid;
        logic [4:0]  e_wa;
        logic [31:0] e_wv;
        logic [31:0] e_cnt;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Behavioural model: retirement bookkeeping expressed as flags and values.
    bit            m_waiting, m_flushing;
    bit            m_wf, m_sc, m_clr, m_rv;
    logic [RW-1:0] m_rid, m_sid;
    logic [4:0]    m_wa;
    logic [31:0]   m_wv, m_pc, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(bit r, bit hv, bit hr, logic [1:0] typ, logic [RW-1:0] id,
                                 logic [4:0] rd, logic [31:0] val, bit mp,
                                 logic [31:0] tgt, bit sd);
        stim_t s;
        s.rst = 1'b0; s.rdy = r; s.hv = hv; s.hr = hr; s.typ = typ; s.id = id;
        s.rd = rd; s.val = val; s.mp = mp; s.tgt = tgt; s.sd = sd;
        return s;
    endfunction

    function automatic bit model_pop(stim_t s);
        if (s.rst || !s.rdy) return 1'b0;
        if (m_waiting)       return s.sd;
        if (m_flushing)      return 1'b0;
        return s.hv && s.hr && (s.typ != 2'd2);
    endfunction

    task automatic model_step(input stim_t s, input bit popped);
        bit fire, mis, is_store;
        if (s.rst) begin
            m_waiting = 0; m_flushing = 0; m_wf = 0; m_sc = 0; m_clr = 0; m_rv = 0;
            m_rid = '0; m_sid = '0; m_wa = '0; m_wv = '0; m_pc = '0; m_cnt = '0;
        end else if (s.rdy) begin
            fire     = !m_waiting && !m_flushing && s.hv && s.hr;
            is_store = fire && (s.typ == 2'd2);
            mis      = fire && (s.typ == 2'd1) && s.mp;
            m_wf     = fire && (s.typ < 2'd2) && (s.rd != 0);
            if (m_wf) begin m_rid = s.id; m_wa = s.rd; m_wv = s.val; end
            m_clr = mis; m_rv = mis;
            if (mis) m_pc = s.tgt;
            if (is_store) begin
                m_sc = 1; m_sid = s.id; m_waiting = 1;
            end else if (m_waiting && s.sd) begin
                m_sc = 0; m_waiting = 0;
            end
            m_flushing = mis;
            if (popped) m_cnt = m_cnt + 1;
        end
    endtask

    // One clock: drive, check combinational pop, clock, check registered outputs.
    task automatic cycle(input stim_t s, output bit pop_act);
        bit pe;
        rst = s.rst; rdy = s.rdy;
        bus.headValid = s.hv; bus.headReady = s.hr; bus.headType = s.typ;
        bus.headId = s.id; bus.headRd = s.rd; bus.headValue = s.val;
        bus.headMispredict = s.mp; bus.headTarget = s.tgt; bus.storeDone = s.sd;
        #1;
        pop_act = bus.headPop;
        pe = model_pop(s);
        chk("headPop", {31'd0, pop_act}, {31'd0, pe});
        @(posedge clk);
        model_step(s, pe);
        #1;
        chk("writeFlag",     {31'd0, bus.writeFlag},     {31'd0, m_wf});
        chk("robId",         32'(bus.robId),             32'(m_rid));
        chk("writeAddr",     32'(bus.writeAddr),         32'(m_wa));
        chk("writeValue",    bus.writeValue,             m_wv);
        chk("storeCommit",   {31'd0, bus.storeCommit},   {31'd0, m_sc});
        chk("storeRobId",    32'(bus.storeRobId),        32'(m_sid));
        chk("clearOut",      {31'd0, bus.clearOut},      {31'd0, m_clr});
        chk("redirectValid", {31'd0, bus.redirectValid}, {31'd0, m_rv});
        chk("redirectPc",    bus.redirectPc,             m_pc);
        chk("commitCount",   bus.commitCount,            m_cnt);
    endtask

    vec_t  vt[11];
    stim_t s;
    bit    p;

    initial begin
        // Directed table: starts right after reset, expectations are absolute.
        vt[0]  = '{mk(1,1,1,0,3,5,32'h1234,0,0,0), 1,1,3,5,32'h1234,1};
        vt[1]  = '{mk(1,1,1,0,4,0,32'h55,0,0,0),   1,0,3,5,32'h1234,2};
        vt[2]  = '{mk(1,0,1,0,5,6,32'h77,0,0,0),   0,0,3,5,32'h1234,2};
        vt[3]  = '{mk(1,1,0,0,5,6,32'h77,0,0,0),   0,0,3,5,32'h1234,2};
        vt[4]  = '{mk(0,1,1,0,5,6,32'h77,0,0,0),   0,0,3,5,32'h1234,2};
        vt[5]  = '{mk(1,1,1,0,5,6,32'h77,0,0,0),   1,1,5,6,32'h77,3};
        vt[6]  = '{mk(0,1,1,0,6,7,32'h88,0,0,0),   0,1,5,6,32'h77,3};
        vt[7]  = '{mk(1,1,1,0,6,7,32'h88,0,0,0),   1,1,6,7,32'h88,4};
        vt[8]  = '{mk(1,1,1,3,7,9,32'h99,0,0,0),   1,0,6,7,32'h88,5};
        vt[9]  = '{mk(1,1,1,0,8,10,32'hA0,0,0,0),  1,1,8,10,32'hA0,6};
        vt[10] = '{mk(1,1,1,0,9,11,32'hB0,0,0,0),  1,1,9,11,32'hB0,7};

        s = mk(1,1,1,0,0,0,0,0,0,0);
        s.rst = 1'b1;
        cycle(s, p);
        cycle(s, p);
        chk("rst_writeFlag",   {31'd0, bus.writeFlag},   32'd0);
        chk("rst_storeCommit", {31'd0, bus.storeCommit}, 32'd0);
        chk("rst_clearOut",    {31'd0, bus.clearOut},    32'd0);
        chk("rst_commitCount", bus.commitCount,          32'd0);

        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].s, p);
            chk($sformatf("vec%0d_pop", i), {31'd0, p}, {31'd0, vt[i].e_pop});
            chk($sformatf("vec%0d_wf", i),  {31'd0, bus.writeFlag}, {31'd0, vt[i].e_wf});
            chk($sformatf("vec%0d_rid", i), 32'(bus.robId),     32'(vt[i].e_rid));
            chk($sformatf("vec%0d_wa", i),  32'(bus.writeAddr), 32'(vt[i].e_wa));
            chk($sformatf("vec%0d_wv", i),  bus.writeValue,     vt[i].e_wv);
            chk($sformatf("vec%0d_cnt", i), bus.commitCount,    vt[i].e_cnt);
        end

        // Store id 7, acknowledged three cycles after the fire.
        s = mk(1,1,1,2,7,3,0,0,0,0);
        cycle(s, p);
        chk("st_fire_pop", {31'd0, p}, 32'd0);
        chk("st_commit",   {31'd0, bus.storeCommit}, 32'd1);
        chk("st_robid",    32'(bus.storeRobId), 32'd7);
        for (int i = 0; i < 2; i++) begin
            cycle(s, p);
            chk("st_wait_pop", {31'd0, p}, 32'd0);
            chk("st_hold",     {31'd0, bus.storeCommit}, 32'd1);
        end
        s.sd = 1'b1;
        cycle(s, p);
        chk("st_done_pop", {31'd0, p}, 32'd1);
        chk("st_release",  {31'd0, bus.storeCommit}, 32'd0);
        chk("st_count",    bus.commitCount, 32'd8);
        cycle(mk(1,1,1,0,1,2,32'h3,0,0,0), p);
        chk("st_run_pop",  {31'd0, p}, 32'd1);

        // Branch mispredict followed by the flush bubble.
        cycle(mk(1,1,1,1,2,1,32'h40,1,32'h100,0), p);
        chk("mp_pop",      {31'd0, p}, 32'd1);
        chk("mp_wf",       {31'd0, bus.writeFlag}, 32'd1);
        chk("mp_wa",       32'(bus.writeAddr), 32'd1);
        chk("mp_wv",       bus.writeValue, 32'h40);
        chk("mp_clear",    {31'd0, bus.clearOut}, 32'd1);
        chk("mp_redir",    {31'd0, bus.redirectValid}, 32'd1);
        chk("mp_pc",       bus.redirectPc, 32'h100);
        cycle(mk(1,1,1,0,3,4,32'h5,0,0,0), p);
        chk("flush_pop",   {31'd0, p}, 32'd0);
        chk("flush_clear", {31'd0, bus.clearOut}, 32'd0);
        cycle(mk(1,1,1,0,3,4,32'h5,0,0,0), p);
        chk("post_flush_pop", {31'd0, p}, 32'd1);

        // Reset while a store is outstanding.
        cycle(mk(1,1,1,2,5,0,0,0,0,0), p);
        chk("rs_commit",   {31'd0, bus.storeCommit}, 32'd1);
        s = mk(1,1,1,2,5,0,0,0,0,1);
        s.rst = 1'b1;
        cycle(s, p);
        chk("rs_pop",      {31'd0, p}, 32'd0);
        chk("rs_commit0",  {31'd0, bus.storeCommit}, 32'd0);
        chk("rs_count",    bus.commitCount, 32'd0);
        cycle(mk(1,1,1,0,6,8,32'h9,0,0,0), p);
        chk("rs_run_pop",  {31'd0, p}, 32'd1);
        chk("rs_run_cnt",  bus.commitCount, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            s.rst = ($urandom_range(0, 99) < 2);
            s.rdy = ($urandom_range(0, 99) < 80);
            s.hv  = ($urandom_range(0, 99) < 85);
            s.hr  = ($urandom_range(0, 99) < 80);
            s.typ = 2'($urandom_range(0, 3));
            s.id  = RW'($urandom);
            s.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            s.val = $urandom;
            s.mp  = $urandom_range(0, 1) == 1;
            s.tgt = $urandom;
            s.sd  = ($urandom_range(0, 99) < 35);
            cycle(s, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit_controller.md
COMMIT_CONTROLLER -- requirements
Module: commit_controller

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, the ROB index width shared with the register file rename tags.
REQ-002 SHALL have port clockIn  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetIn  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port readyIn  input  1  global enable; low freezes all state.
REQ-005 SHALL have ROB head inputs (input): headValid 1 (head entry exists), headReady 1 (result available), headId ROB_WIDTH (head tag), headType 2 (0 REG, 1 BRANCH, 2 STORE, 3 OTHER), headRd 5 (destination), headValue 32 (result), headMispredict 1, headTarget 32 (correct PC).
REQ-006 SHALL have port headPop  output  1  combinational dequeue strobe to the ROB.
REQ-007 SHALL have register-file write outputs (output): writeFlag 1, robId ROB_WIDTH, writeAddr 5, writeValue 32.
REQ-008 SHALL have store commit ports: storeCommit output 1, storeRobId output ROB_WIDTH, storeDone input 1.
REQ-009 SHALL have flush outputs (output): clearOut 1 (to register file and all queues), redirectValid 1, redirectPc 32.
REQ-010 SHALL have port commitCount  output  32  count of retired entries.

Function
REQ-011 SHALL implement states RUN, WAIT_STORE, FLUSH.
REQ-012 "Fire" SHALL mean readyIn && headValid && headReady in RUN.
REQ-013 headPop SHALL be 1 only on a fire of type REG, BRANCH or OTHER in RUN, or in WAIT_STORE with readyIn && storeDone; else 0.
REQ-014 On a REG/BRANCH fire with headRd != 0, next cycle writeFlag SHALL be 1 with robId=headId, writeAddr=headRd, writeValue=headValue (latency 1).
REQ-015 headRd == 0 SHALL still pop but SHALL leave writeFlag 0.
REQ-016 writeFlag, clearOut, redirectValid SHALL be one-cycle pulses, cleared on the next readyIn-high edge unless re-fired.
REQ-017 On a STORE fire: no pop; next state WAIT_STORE; storeCommit<=1, storeRobId<=headId.
REQ-018 In WAIT_STORE, storeCommit SHALL hold 1 until a readyIn-high cycle with storeDone=1: pop that cycle, storeCommit<=0, return to RUN.
REQ-019 On a BRANCH fire with headMispredict=1: pop, rd write per REQ-014, next cycle clearOut=1, redirectValid=1, redirectPc=headTarget, state FLUSH.
REQ-020 FLUSH SHALL last exactly one cycle with headPop=0, then return to RUN.
REQ-021 commitCount SHALL increment by 1 on every headPop cycle, wrapping 2^32-1 -> 0.
REQ-022 readyIn=0 SHALL force headPop=0 and hold state, all registered outputs and commitCount.
REQ-023 headValid=0 or headReady=0 in RUN SHALL produce no pop and no write.
REQ-024 Back-to-back REG fires SHALL commit one entry per cycle without bubbles.

Reset
REQ-025 resetIn SHALL force state RUN, writeFlag/storeCommit/clearOut/redirectValid 0, robId/writeAddr/storeRobId 0, writeValue/redirectPc/commitCount 0.
REQ-026 Reset SHALL take priority over readyIn and any in-progress WAIT_STORE/FLUSH; headPop SHALL be 0 during reset.

Structure
REQ-027 headType encodings and ROB_WIDTH default SHALL live in the shared CPU package/header used by the ROB and decoder.
REQ-028 SHALL be a single module with no sub-modules; the state register is a 2-bit encoding.

Verification
REQ-029 REG commit: head {id 3, rd 5, value 0x1234} ready -> headPop same cycle; next cycle writeFlag=1, robId=3, writeAddr=5, writeValue=0x1234; commitCount=1.
REQ-030 x0: REG head rd 0 -> headPop=1, writeFlag stays 0, commitCount increments.
REQ-031 Store: STORE head id 7 -> storeCommit=1/storeRobId=7 until storeDone pulsed 3 cycles later; pop in that cycle; RUN next.
REQ-032 Mispredict: BRANCH id 2, rd 1, value 0x40, target 0x100 -> pop, then write x1=0x40, clearOut=1, redirectPc=0x100 same cycle; no pop in FLUSH cycle.
REQ-033 Stall: readyIn=0 for 2 cycles with ready head -> headPop 0, outputs held; readyIn=1 -> commit resumes one per cycle.
REQ-034 Reset in WAIT_STORE: storeCommit=1, assert resetIn -> next cycle storeCommit=0, state RUN, commitCount=0.
